iob_rom_dp_streamer: RTL and testbench
======================================

# iob_rom_dp_streamer

Read-sequencer stage that sits directly upstream of one port of a dual-port ROM. On a start command it walks a contiguous address range, issues single-word reads with the ROM's one-cycle registered latency, and presents the returned words on a valid/ready stream. A two-entry skid FIFO absorbs downstream back-pressure without losing in-flight reads. Sustained throughput is one word per cycle while `ready_i` is held high.

## Interface
- `DATA_W`, 32, ROM word width.
- `ADDR_W`, 11, ROM address width; ROM depth is 2**ADDR_W.
- `clk_i` in 1: clock, rising edge.
- `arst_n_i` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start command; sampled only in IDLE.
- `base_addr_i` in ADDR_W: first word address; latched on start.
- `len_i` in ADDR_W+1: word count, 0..2**ADDR_W; latched on start.
- `busy_o` out 1: high from the cycle after an accepted start until `done_o`.
- `done_o` out 1: one-cycle pulse when the transfer completes.
- `rom_addr_o` out ADDR_W: to ROM port address.
- `rom_r_en_o` out 1: to ROM port read enable.
- `rom_r_data_i` in DATA_W: ROM read data, valid the cycle after `rom_r_en_o`.
- `data_o` out DATA_W: stream data.
- `valid_o` out 1: stream valid.
- `ready_i` in 1: stream ready.
- `last_o` out 1: marks the final word; present only with the macro (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start_i` with `len_i`≠0: latch base and length, go to RUN.
  - `start_i` with `len_i`=0: no ROM read; `done_o` pulses next cycle; stay in IDLE.
- RUN:
  - Issue when `count + inflight_q - pop ≤ 1`, where `count` is FIFO occupancy (0..2), `inflight_q` is the registered `rom_r_en_o` of the previous cycle, and `pop = valid_o & ready_i`.
  - Issuing means `rom_r_en_o`=1 with `rom_addr_o` = current address; the address then increments modulo 2**ADDR_W, so wrap from 2**ADDR_W-1 to 0 is legal.
  - After the cycle that issues the final read, go to DRAIN.
- DRAIN: when `count`=0 and `inflight_q`=0, pulse `done_o` and go to IDLE.
- FIFO:
  - When `inflight_q`=1, `rom_r_data_i` is written at the end of that cycle.
  - `data_o` and `valid_o` reflect the FIFO head.
  - Simultaneous write and pop in the same cycle keeps `count` unchanged.
  - Overflow is impossible by construction; verification asserts `count` ≤ 2.
- `start_i` is ignored while `busy_o`=1.
- `rom_addr_o` holds its last value when not reading.
- `data_o` holds while `valid_o`=1 and `ready_i`=0 (standard stable-while-stalled rule).

## Timing
- Reset value of every output is 0: `busy_o`, `done_o`, `rom_addr_o`, `rom_r_en_o`, `data_o`, `valid_o`, `last_o`.
- Reset asserted mid-transfer: all state clears immediately. Any read in flight is dropped and `done_o` is not pulsed.
- Start latency, with `start_i` high in cycle 0:
  - `rom_r_en_o` is high in cycle 1.
  - ROM data is valid in cycle 2.
  - `valid_o` first rises in cycle 3.
- With `ready_i` held at 1, words stream one per cycle with no bubbles. `done_o` pulses one cycle after the last handshake.
- `ready_i` dropped for N cycles: at most 2 words buffer, reads stall, and streaming resumes with no loss or duplication.

## Configuration
- `IOB_ROM_DP_STREAMER_LAST_EN` defined:
  - A `last_o` port exists; a per-entry last flag is stored alongside the data in the FIFO.
  - `last_o`=1 exactly on the final word of each transfer, qualified by `valid_o`.
- Not defined: the port and the flag storage are omitted; all other behaviour is identical.

## Test plan
- ROM[i]=i+0x100, base=4, len=8, `ready_i`=1 -> `valid_o` first high in cycle 3; `data_o` = 0x104..0x10B on 8 consecutive cycles; `done_o` in cycle 11; `last_o` on 0x10B when the macro is defined.
- Wrap, ADDR_W=4: base=14, len=4 -> `rom_addr_o` sequence 14, 15, 0, 1; data matches ROM contents in that order.
- Back-pressure: len=6 with `ready_i` toggling 1,0,0,1,… -> the 6 words arrive in order with no duplicates; FIFO `count` never exceeds 2; `rom_r_en_o` stalls while the FIFO is full.
- len=0 start -> `rom_r_en_o` never asserts; `done_o` pulses next cycle; `busy_o` stays 0.
- `start_i` asserted while busy (len=5) -> ignored; exactly 5 words and one `done_o` pulse are produced.
- Full-range len=2**ADDR_W -> every ROM word is streamed once, in order.
- `arst_n_i` low during word 3 of 8 -> all outputs read 0 immediately. A new start after release streams from the new base correctly.

Source files
------------

// File: rtl/iob_rom_dp_streamer.sv
// -----------------------------------------------------------------------------
// iob_rom_dp_streamer
//
// Read sequencer for one port of a dual-port ROM. A start command latches a
// base address and word count; the block then issues single-word reads
// (one-cycle registered ROM latency) and streams the returned words out on a
// valid/ready interface. A two-entry skid FIFO holds words that are already
// in flight when the consumer stalls, so back-pressure never loses data and
// throughput is one word per cycle while ready_i stays high.
//
// Optional feature macro: IOB_ROM_DP_STREAMER_LAST_EN
//   defined   -> last_o port exists; a last flag rides with each FIFO entry.
//   undefined -> no last_o port and no flag storage.
//
// Ports:
//   clk_i, arst_n_i      clock (rising edge), async active-low reset
//   start_i              start command, sampled only in IDLE
//   base_addr_i, len_i   first address / word count (0..2**ADDR_W), latched
//   busy_o, done_o       transfer in progress / one-cycle completion pulse
//   rom_addr_o,
//   rom_r_en_o,
//   rom_r_data_i         ROM port (data valid the cycle after rom_r_en_o)
//   data_o, valid_o,
//   ready_i              output stream
//   last_o               final-word marker (macro builds only)
// -----------------------------------------------------------------------------
module iob_rom_dp_streamer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_r_en_o,
   input  logic [DATA_W-1:0] rom_r_data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i
`ifdef IOB_ROM_DP_STREAMER_LAST_EN
   ,
   output logic              last_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;     // next address to read
   logic [ADDR_W:0]     rem_q, rem_d;       // reads still to issue
   logic [ADDR_W-1:0]   raddr_q, raddr_d;   // last address driven to the ROM
   logic                zdone_q, zdone_d;   // done pulse for a zero-length start
   logic                inflight_q;         // read issued last cycle
   logic [1:0]          count_q, count_d;   // FIFO occupancy 0..2
   logic                wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0]   mem_q [2];

   logic                issue;
   logic                issue_ok;
   logic                drain_done;
   logic                pop;

   assign valid_o = (count_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign pop     = valid_o & ready_i;

   // Only issue if the word will have a free FIFO slot when it lands:
   // occupancy next cycle (count + inflight - pop) must leave room for it.
   assign issue_ok = ({1'b0, count_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});

   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = zdone_q | drain_done;
   assign rom_r_en_o = issue;
   // Address holds its last value between reads rather than showing addr_q.
   assign rom_addr_o = issue ? addr_q : raddr_q;
   assign raddr_d    = rom_addr_o;
   assign count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      zdone_d    = 1'b0;
      issue      = 1'b0;
      drain_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d = S_RUN;
                  addr_d  = base_addr_i;
                  rem_d   = len_i;
               end else begin
                  zdone_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (issue_ok) begin
               issue  = 1'b1;
               addr_d = addr_q + ADDR_W'(1);   // wraps modulo 2**ADDR_W
               rem_d  = rem_q - (ADDR_W+1)'(1);
               if (rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (count_q == 2'd0 && !inflight_q) begin
               drain_done = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         raddr_q    <= '0;
         zdone_q    <= 1'b0;
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         raddr_q    <= raddr_d;
         zdone_q    <= zdone_d;
         inflight_q <= issue;
         count_q    <= count_d;
         if (inflight_q) begin
            mem_q[wr_ptr_q] <= rom_r_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
      end
   end

`ifdef IOB_ROM_DP_STREAMER_LAST_EN
   // Last flag follows the final read through the ROM latency into the FIFO.
   logic last_inf_q;
   logic lmem_q [2];

   assign last_o = valid_o & lmem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         last_inf_q <= 1'b0;
         lmem_q[0]  <= 1'b0;
         lmem_q[1]  <= 1'b0;
      end else begin
         last_inf_q <= issue & (rem_q == (ADDR_W+1)'(1));
         if (inflight_q) lmem_q[wr_ptr_q] <= last_inf_q;
      end
   end
`endif

endmodule

// File: tb/tb_iob_rom_dp_streamer.sv
module tb_iob_rom_dp_streamer;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk_i = 1'b0;
   logic          arst_n_i;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [AW:0]   len_i;
   logic          busy_o, done_o;
   logic [AW-1:0] rom_addr_o;
   logic          rom_r_en_o;
   logic [DW-1:0] rom_r_data_i;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;
`ifdef IOB_ROM_DP_STREAMER_LAST_EN
   logic          last_o;
`endif

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] exp_d [$];
   logic [AW-1:0] exp_a [$];
   logic          exp_l [$];

   int first_v, first_hs, last_hs, n_hs, done_cyc, n_done, n_rd;
   bit busy_seen;

   always #5 clk_i = ~clk_i;

   iob_rom_dp_streamer #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
      .clk_i       (clk_i),
      .arst_n_i    (arst_n_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .len_i       (len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .rom_addr_o  (rom_addr_o),
      .rom_r_en_o  (rom_r_en_o),
      .rom_r_data_i(rom_r_data_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i)
`ifdef IOB_ROM_DP_STREAMER_LAST_EN
      ,
      .last_o      (last_o)
`endif
   );

   // ROM model: ROM[i] = i + 0x100, one-cycle registered read
   initial rom_r_data_i = '0;
   always @(posedge clk_i) if (rom_r_en_o) rom_r_data_i <= 32'h100 + 32'(rom_addr_o);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_addr"}, rom_addr_o, 0);
      chk({tag, "_ren"}, rom_r_en_o, 0);
      chk({tag, "_data"}, data_o, 0);
      chk({tag, "_valid"}, valid_o, 0);
`ifdef IOB_ROM_DP_STREAMER_LAST_EN
      chk({tag, "_last"}, last_o, 0);
`endif
   endtask

   // mode 0: ready always 1; mode 1: ready = 1,0,0,1,0,0,...
   // restart_at: cycle at which a (to be ignored) start is driven
   // rst_at_hs: assert reset right after this many handshakes (0 = never)
   task automatic run_xfer(input int base, input int len, input int mode,
                           input int restart_at, input int rst_at_hs);
      bit            rst_hit = 0;
      bit            prev_stall = 0;
      logic [DW-1:0] prev_data = '0;
      first_v = -1; first_hs = -1; last_hs = -1; n_hs = 0;
      done_cyc = -1; n_done = 0; n_rd = 0; busy_seen = 0;
      for (int k = 0; k < len; k++) begin
         exp_a.push_back(AW'((base + k) % DEPTH));
         exp_d.push_back(32'h100 + 32'((base + k) % DEPTH));
         exp_l.push_back(k == len - 1);
      end
      @(posedge clk_i); #1;
      start_i = 1'b1; base_addr_i = AW'(base); len_i = (AW+1)'(len); ready_i = 1'b1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(posedge clk_i); #1;
         start_i = (cyc == restart_at);
         if (cyc == restart_at) begin base_addr_i = '0; len_i = 5; end
         ready_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         @(negedge clk_i);
         if (busy_o) busy_seen = 1;
         if (prev_stall) chk("hold_data", data_o, prev_data);
         if (rom_r_en_o) begin
            n_rd++;
            if (exp_a.size() == 0) chk("extra_read", rom_r_en_o, 0);
            else chk("rom_addr", rom_addr_o, exp_a.pop_front());
         end
         if (busy_o) begin
            chk("count_le2", u_dut.count_q <= 2, 1);
            if (u_dut.count_q == 2 && !ready_i) chk("stall_full", rom_r_en_o, 0);
         end
         if (valid_o && first_v < 0) first_v = cyc;
         if (valid_o && ready_i) begin
            n_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (exp_d.size() == 0) chk("extra_word", valid_o, 0);
            else begin
               chk("data", data_o, exp_d.pop_front());
`ifdef IOB_ROM_DP_STREAMER_LAST_EN
               chk("last", last_o, exp_l[0]);
`endif
               void'(exp_l.pop_front());
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_data  = data_o;
         if (done_o) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (rst_at_hs > 0 && n_hs == rst_at_hs) begin
            arst_n_i = 1'b0;
            rst_hit  = 1;
            break;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      end
      if (!rst_hit) begin
         chk("no_timeout", done_cyc >= 0, 1);
         chk("queue_empty", exp_d.size(), 0);
      end
   endtask

   initial begin
      arst_n_i = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      chk_zero_outputs("reset");
      arst_n_i = 1'b1;
      @(posedge clk_i); #1;

      // basic: base 4, len 8, ready held high
      run_xfer(4, 8, 0, 0, 0);
      chk("t1_first_valid", first_v, 3);
      chk("t1_first_hs", first_hs, 3);
      chk("t1_last_hs", last_hs, 10);
      chk("t1_n_hs", n_hs, 8);
      chk("t1_done_cyc", done_cyc, 11);
      chk("t1_n_done", n_done, 1);

      // wrap: 14, 15, 0, 1
      run_xfer(14, 4, 0, 0, 0);
      chk("wrap_n_hs", n_hs, 4);
      chk("wrap_n_rd", n_rd, 4);

      // back-pressure
      run_xfer(3, 6, 1, 0, 0);
      chk("bp_n_hs", n_hs, 6);
      chk("bp_n_rd", n_rd, 6);
      chk("bp_done_after_last", done_cyc, last_hs + 1);
      chk("bp_n_done", n_done, 1);

      // zero length
      run_xfer(7, 0, 0, 0, 0);
      chk("len0_done_cyc", done_cyc, 1);
      chk("len0_n_done", n_done, 1);
      chk("len0_busy", busy_seen, 0);
      chk("len0_n_rd", n_rd, 0);

      // start while busy is ignored
      run_xfer(1, 5, 0, 2, 0);
      chk("rs_n_hs", n_hs, 5);
      chk("rs_n_done", n_done, 1);
      chk("rs_n_rd", n_rd, 5);

      // full range, starting mid-array so it also wraps
      run_xfer(5, DEPTH, 0, 0, 0);
      chk("full_n_hs", n_hs, DEPTH);
      chk("full_last_hs", last_hs, 3 + DEPTH - 1);
      chk("full_done_cyc", done_cyc, 3 + DEPTH);

      // reset during word 3 of 8
      run_xfer(2, 8, 0, 0, 3);
      #1;
      chk_zero_outputs("midrst");
      exp_a.delete(); exp_d.delete(); exp_l.delete();
      @(posedge clk_i); #1;
      chk("midrst_no_done", done_o, 0);
      @(posedge clk_i); #1;
      arst_n_i = 1'b1;
      run_xfer(9, 5, 0, 0, 0);
      chk("post_rst_n_hs", n_hs, 5);
      chk("post_rst_first_valid", first_v, 3);
      chk("post_rst_n_done", n_done, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
